// File: rtl/uart_pkg.sv
// Shared definitions for the UART command decoder: frame FSM encoding,
// default frame marker and frame length.
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_ADDR = 3'd1,
        S_DATH = 3'd2,
        S_DATL = 3'd3,
        S_CHK  = 3'd4
    } frame_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 5;

endpackage

// File: rtl/uart_rx_cmd_decoder_if.sv
// Command output bus: one-entry valid/ready channel carrying {addr, data}.
interface uart_rx_cmd_decoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/uart_cmd_out_reg.sv
// One-entry valid/ready holding register; a load into an occupied slot that
// is not being drained this cycle is dropped and flagged as overflow.
module uart_cmd_out_reg (
  input  logic                         i_Clock,
  input  logic                         i_Rst_L,
  input  logic                         i_Load,
  input  logic [7:0]                   i_Addr,
  input  logic [15:0]                  i_Data,
  output logic                         o_Err_Ovf,
  uart_rx_cmd_decoder_if.master        cmd
);

  logic        valid_reg, valid_next;
  logic [7:0]  addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic        ovf_reg, ovf_next;
  logic        slot_free;

  // The slot can be refilled in the same cycle the consumer takes it
  assign slot_free = !valid_reg || cmd.cmd_ready;

  always_comb begin
    valid_next = valid_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    ovf_next   = 1'b0;
    if (valid_reg && cmd.cmd_ready) begin
      valid_next = 1'b0;
    end
    if (i_Load) begin
      if (slot_free) begin
        valid_next = 1'b1;
        addr_next  = i_Addr;
        data_next  = i_Data;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      valid_reg <= 1'b0;
      addr_reg  <= 8'h00;
      data_reg  <= 16'h0000;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign cmd.cmd_valid = valid_reg;
  assign cmd.cmd_addr  = addr_reg;
  assign cmd.cmd_data  = data_reg;
  assign o_Err_Ovf     = ovf_reg;

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Assembles SYNC/ADDR/DATA_H/DATA_L/CHK frames from UART bytes and issues good
// commands. Define UART_CMD_TIMEOUT_EN to abandon frames after TIMEOUT_CLKS idle clocks.
module uart_rx_cmd_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  uart_rx_cmd_decoder_if.master cmd,
  output logic                  o_Err_Chk,
  output logic                  o_Err_Ovf,
  output logic                  o_Err_Tmo,
  output logic                  o_Busy
);

  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  frame_state_e state_reg, state_next;
  logic [7:0]   addr_reg, addr_next;
  logic [7:0]   dath_reg, dath_next;
  logic [7:0]   datl_reg, datl_next;
  logic [7:0]   sum_reg, sum_next;
  logic         chk_err_reg, chk_err_next;
  logic         frame_good;
  logic         tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_err_reg;

  // A byte arriving on the deadline cycle takes priority over the timeout
  assign tmo_hit = (state_reg != S_SYNC) && !i_RX_DV &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT_CLKS));

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg + 1'b1;
    if (i_RX_DV || (state_reg == S_SYNC) || tmo_hit) begin
      tmo_cnt_next = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      tmo_err_reg <= tmo_hit;
    end
  end

  assign o_Err_Tmo = tmo_err_reg;
`else
  assign tmo_hit   = 1'b0;
  assign o_Err_Tmo = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    dath_next    = dath_reg;
    datl_next    = datl_reg;
    sum_next     = sum_reg;
    chk_err_next = 1'b0;
    frame_good   = 1'b0;
    if (i_RX_DV) begin
      case (state_reg)
        S_SYNC: begin
          if (i_RX_Byte == SYNC_BYTE) state_next = S_ADDR;
        end
        S_ADDR: begin
          addr_next  = i_RX_Byte;
          sum_next   = i_RX_Byte;
          state_next = S_DATH;
        end
        S_DATH: begin
          dath_next  = i_RX_Byte;
          sum_next   = sum_reg + i_RX_Byte;
          state_next = S_DATL;
        end
        S_DATL: begin
          datl_next  = i_RX_Byte;
          sum_next   = sum_reg + i_RX_Byte;
          state_next = S_CHK;
        end
        S_CHK: begin
          state_next = S_SYNC;
          if (i_RX_Byte == sum_reg) frame_good   = 1'b1;
          else                      chk_err_next = 1'b1;
        end
        default: state_next = S_SYNC;
      endcase
    end else if (tmo_hit) begin
      state_next = S_SYNC;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg   <= S_SYNC;
      addr_reg    <= 8'h00;
      dath_reg    <= 8'h00;
      datl_reg    <= 8'h00;
      sum_reg     <= 8'h00;
      chk_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      dath_reg    <= dath_next;
      datl_reg    <= datl_next;
      sum_reg     <= sum_next;
      chk_err_reg <= chk_err_next;
    end
  end

  uart_cmd_out_reg u_out_reg (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Load    (frame_good),
    .i_Addr    (addr_reg),
    .i_Data    ({dath_reg, datl_reg}),
    .o_Err_Ovf (o_Err_Ovf),
    .cmd       (cmd)
  );

  assign o_Err_Chk = chk_err_reg;
  assign o_Busy    = (state_reg != S_SYNC);

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: directed frames plus randomized frames checked
// every cycle against a byte-list reference model.
module tb_uart_rx_cmd_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 4340;

  logic       i_Clock = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic       o_Err_Chk, o_Err_Ovf, o_Err_Tmo, o_Busy;

  uart_rx_cmd_decoder_if cmd_if ();

  uart_rx_cmd_decoder dut (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_RX_DV   (i_RX_DV),
    .i_RX_Byte (i_RX_Byte),
    .cmd       (cmd_if.master),
    .o_Err_Chk (o_Err_Chk),
    .o_Err_Ovf (o_Err_Ovf),
    .o_Err_Tmo (o_Err_Tmo),
    .o_Busy    (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the frame collected so far, plus the output slot
  logic [7:0]  m_frame [$];
  logic        m_valid;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic        m_chk, m_ovf, m_tmo;
  int          m_idle;

  logic        rdy_random = 1'b0;
  logic        rdy_fixed  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_valid = 1'b0; m_addr = 8'h00; m_data = 16'h0000;
    m_chk = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_idle = 0;
  endtask

  // Applies one clock edge's worth of the decoding rules to the model
  task automatic model_edge(input logic dv, input logic [7:0] b, input logic rdy);
    logic [7:0] sum;
    logic       take;
    take  = m_valid && rdy;
    m_chk = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
    if (take) m_valid = 1'b0;
    if (dv) begin
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (b == SYNC) m_frame.push_back(b);
      end else if (m_frame.size() < 4) begin
        m_frame.push_back(b);
      end else begin
        sum = m_frame[1] + m_frame[2] + m_frame[3];
        if (b == sum) begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_addr  = m_frame[1];
            m_data  = {m_frame[2], m_frame[3]};
          end else begin
            m_ovf = 1'b1;
          end
        end else begin
          m_chk = 1'b1;
        end
        m_frame.delete();
      end
    end else if (m_frame.size() > 0) begin
`ifdef UART_CMD_TIMEOUT_EN
      m_idle++;
      if (m_idle > TMO) begin
        m_tmo = 1'b1;
        m_idle = 0;
        m_frame.delete();
      end
`endif
    end
  endtask

  function automatic logic pick_ready();
    return rdy_random ? 1'($urandom_range(0, 1)) : rdy_fixed;
  endfunction

  task automatic step(input logic dv, input logic [7:0] b);
    logic rdy;
    rdy = pick_ready();
    i_RX_DV = dv;
    i_RX_Byte = b;
    cmd_if.cmd_ready = rdy;
    @(posedge i_Clock);
    model_edge(dv, b, rdy);
    #1;
    check("valid", cmd_if.cmd_valid, m_valid);
    check("addr", cmd_if.cmd_addr, m_addr);
    check("data", cmd_if.cmd_data, m_data);
    check("err_chk", o_Err_Chk, m_chk);
    check("err_ovf", o_Err_Ovf, m_ovf);
    check("err_tmo", o_Err_Tmo, m_tmo);
    check("busy", o_Busy, m_frame.size() > 0);
    $display("step dv=%0d byte=%02h rdy=%0d valid=%0d addr=%02h data=%04h chk=%0d ovf=%0d tmo=%0d busy=%0d",
             dv, b, rdy, cmd_if.cmd_valid, cmd_if.cmd_addr, cmd_if.cmd_data,
             o_Err_Chk, o_Err_Ovf, o_Err_Tmo, o_Busy);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] c);
    send(SYNC, 0); send(a, 0); send(dh, 0); send(dl, 0); send(c, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, cmd_if.cmd_valid, 0);
    check({tag, "_addr"},  cmd_if.cmd_addr, 0);
    check({tag, "_data"},  cmd_if.cmd_data, 0);
    check({tag, "_errs"},  {o_Err_Chk, o_Err_Ovf, o_Err_Tmo}, 0);
    check({tag, "_busy"},  o_Busy, 0);
  endtask

  initial begin
    int tmo_pulses;
    logic [7:0] a, dh, dl, c, j;

    cmd_if.cmd_ready = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    i_Rst_L = 1'b1;
    #10;

    // Good frame, consumer ready
    rdy_fixed = 1'b1;
    send_frame(8'h10, 8'h12, 8'h34, 8'h56);
    check("f1_valid", cmd_if.cmd_valid, 1);
    check("f1_addr", cmd_if.cmd_addr, 8'h10);
    check("f1_data", cmd_if.cmd_data, 16'h1234);
    check("f1_errs", {o_Err_Chk, o_Err_Ovf, o_Err_Tmo}, 0);
    step(1'b0, 8'h00);

    // Bad checksum
    send_frame(8'h10, 8'h12, 8'h34, 8'h57);
    check("bad_chk", o_Err_Chk, 1);
    check("bad_valid", cmd_if.cmd_valid, 0);
    step(1'b0, 8'h00);
    check("bad_chk_gone", o_Err_Chk, 0);
    check("bad_busy", o_Busy, 0);

    // Leading junk ignored, checksum wraps
    rdy_fixed = 1'b0;
    send(8'hFF, 0); send(8'h00, 0);
    send_frame(8'h80, 8'hFF, 8'hFF, 8'h7E);
    check("junk_valid", cmd_if.cmd_valid, 1);
    check("junk_addr", cmd_if.cmd_addr, 8'h80);
    check("junk_data", cmd_if.cmd_data, 16'hFFFF);
    rdy_fixed = 1'b1;
    step(1'b0, 8'h00);
    check("junk_drained", cmd_if.cmd_valid, 0);

    // Overflow: second good frame while first is held
    rdy_fixed = 1'b0;
    send_frame(8'h01, 8'h02, 8'h03, 8'h06);
    send_frame(8'h04, 8'h05, 8'h06, 8'h0F);
    check("ovf_pulse", o_Err_Ovf, 1);
    check("ovf_hold_addr", cmd_if.cmd_addr, 8'h01);
    check("ovf_hold_data", cmd_if.cmd_data, 16'h0203);
    step(1'b0, 8'h00);
    check("ovf_gone", o_Err_Ovf, 0);
    check("ovf_still_valid", cmd_if.cmd_valid, 1);
    rdy_fixed = 1'b1;
    step(1'b0, 8'h00);
    check("ovf_delivered", cmd_if.cmd_valid, 0);
    step(1'b0, 8'h00);
    check("ovf_no_second", cmd_if.cmd_valid, 0);

    // Idle gap inside a frame
    send(SYNC, 0); send(8'h10, 0);
    tmo_pulses = 0;
    repeat (TMO + 5) begin
      step(1'b0, 8'h00);
      if (o_Err_Tmo) tmo_pulses++;
    end
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo_pulses", tmo_pulses, 1);
    check("tmo_busy", o_Busy, 0);
    send_frame(8'h10, 8'h12, 8'h34, 8'h56);
    check("tmo_next_valid", cmd_if.cmd_valid, 1);
    check("tmo_next_data", cmd_if.cmd_data, 16'h1234);
`else
    check("notmo_pulses", tmo_pulses, 0);
    check("notmo_busy", o_Busy, 1);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    check("notmo_valid", cmd_if.cmd_valid, 1);
    check("notmo_data", cmd_if.cmd_data, 16'h1234);
`endif
    step(1'b0, 8'h00);

    // Asynchronous reset mid-frame with a command held
    rdy_fixed = 1'b0;
    send_frame(8'h22, 8'h33, 8'h44, 8'h99);
    send(SYNC, 0); send(8'h10, 0); send(8'h12, 0);
    check("pre_rst_valid", cmd_if.cmd_valid, 1);
    i_RX_DV = 1'b0;
    #3 i_Rst_L = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(posedge i_Clock);
    #3 i_Rst_L = 1'b1;
    send(8'h34, 1); send(8'h56, 0);
    step(1'b0, 8'h00);
    check("post_rst_valid", cmd_if.cmd_valid, 0);
    check("post_rst_chk", o_Err_Chk, 0);

    // Randomized frames with junk, gaps, corrupted checksums and random ready
    rdy_random = 1'b1;
    for (int f = 0; f < 60; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        j = 8'($urandom);
        if (j == SYNC) j = 8'h00;
        send(j, $urandom_range(0, 2));
      end
      a = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
      c = a + dh + dl;
      if ($urandom_range(0, 3) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
      send(SYNC, $urandom_range(0, 2));
      send(a, $urandom_range(0, 2));
      send(dh, $urandom_range(0, 2));
      send(dl, $urandom_range(0, 2));
      send(c, $urandom_range(0, 2));
    end
    repeat (4) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
